fast_slow_fifo_bridge: RTL and testbench
========================================

Name: fast_slow_fifo_bridge

Overview:
- Derives a slow clock from fast_clk with an integer toggle divider.
- Carries a data stream from the fast_clk domain into that slow domain through a dual-clock FIFO.
- The FIFO uses Gray-coded pointers and two-flop pointer synchronisers.
- Sits between a fast producer (counter, sampler) and slow-domain consumers. It also exports the slow clock so consumers share it.

Parameters:
- FAST_CLK_HZ, 40_000_000, frequency of fast_clk.
- SLOW_CLK_HZ, 10_000_000, generated slow clock frequency. HALF = FAST_CLK_HZ/(2*SLOW_CLK_HZ) must be an integer ≥1; elaboration error otherwise.
- CLK_INIT, 1'b0, slow clock level during and directly after reset.
- BITS, 8, data word width.
- ADDR_BITS, 8, FIFO address width; depth = 2**ADDR_BITS.

Ports:
- fast_clk  in  1  main clock; write domain.
- rst  in  1  synchronous active-high reset, sampled on fast_clk.
- in_insert  in  1  write request (fast domain).
- in_remove  in  1  read/pop request (slow domain).
- in_data  in  BITS  write data.
- out_slow_clk  out  1  generated slow clock; read domain.
- out_data  out  BITS  front word of FIFO (slow domain).
- out_full  out  1  full flag (fast domain).
- out_empty  out  1  empty flag (slow domain).

Behaviour:
- Divider (fast_clk):
  - counter 0..HALF-1.
  - When the counter equals HALF-1: counter ← 0 and out_slow_clk toggles.
  - rst: counter ← 0, out_slow_clk ← CLK_INIT.
  - Default: slow rising edge every 4 fast cycles, first one 2 fast cycles after reset release.
- Slow-domain reset rst_slow (fast-domain register):
  - set on rst.
  - cleared on the fast edge after the first slow_clk rising edge following rst release.
  - All read-side registers reset synchronously on slow_clk while rst_slow=1.
- Write side (fast_clk):
  - wr_ptr is ADDR_BITS+1-bit binary with a registered Gray copy.
  - When in_insert & !out_full: mem[wr_ptr[ADDR_BITS-1:0]] ← in_data, wr_ptr+1, Gray updated on the same edge.
  - Insert when full is ignored: no write, pointer unchanged.
  - rst: wr_ptr ← 0, Gray ← 0.
- Read side (slow_clk):
  - When in_remove & !out_empty: rd_ptr+1, Gray updated.
  - Remove when empty is ignored.
  - Reset: rd_ptr ← 0.
- Synchronisers:
  - write Gray → two flops on slow_clk.
  - read Gray → two flops on fast_clk.
  - Synchroniser flops reset with their domain's reset.
- Flags:
  - out_empty = (rd_gray == wr_gray_sync).
  - out_full = (wr_gray == {~rd_gray_sync[top two bits], rd_gray_sync[remaining]}).
  - Both are combinational from registers and pessimistic, i.e. they deassert late, never early.
  - Reset: out_empty=1, out_full=0.
- out_data:
  - first-word-fall-through: mem[rd_ptr[ADDR_BITS-1:0]] when !out_empty, else 0.
  - reset value 0.
- Latency:
  - A word written at fast edge N appears on out_data and clears out_empty after the 2nd slow rising edge following N.
  - A slot freed by a pop is reported to out_full after 2 fast edges.
- Wrap-around: pointer MSB distinguishes full from empty. The address wraps modulo depth, with no data corruption across wrap.
- Simultaneous insert and remove in their respective domains are both honoured.
- Reset mid-operation:
  - contents discarded.
  - pointers and flags return to reset values.
  - words in flight are lost.
- Memory array is not reset.

Test Plan:
- Reset then idle (insert=remove=0): out_slow_clk=CLK_INIT during rst, toggles every 2 fast cycles after; out_empty=1, out_full=0, out_data=0.
- Single write 0xA5 with remove=0: out_empty drops after 2nd slow rising edge; out_data=0xA5; pop once → out_empty=1, out_data=0.
- Continuous counter 0,1,2,... on in_data, insert=remove=1: out_data advances monotonically by 1 per slow cycle with no skipped or repeated values. Data falls behind since writes are 4× faster. out_full eventually asserts, and further inserts are dropped without corrupting stored words.
- Fill with remove=0: after 256 inserts (ADDR_BITS=8) out_full=1; the 257th insert is ignored; drain all 256 words → exact sequence, then out_empty=1.
- Wrap: fill 200, drain 200, fill 200 → pointers wrap past 256 and read order is correct.
- Assert rst with FIFO half full: after reset, out_empty=1, out_full=0, out_data=0; the first new word written is the first word read.

Source files
------------

// File: rtl/fast_slow_fifo_bridge.sv
// Fast-to-slow clock bridge: toggle divider produces the slow clock, and a dual-clock
// FIFO with Gray-coded, two-flop synchronised pointers carries words into that domain.
module fast_slow_fifo_bridge #(
    parameter int unsigned FAST_CLK_HZ = 40_000_000,
    parameter int unsigned SLOW_CLK_HZ = 10_000_000,
    parameter logic        CLK_INIT    = 1'b0,
    parameter int unsigned BITS        = 8,
    parameter int unsigned ADDR_BITS   = 8
) (
    input  logic            fast_clk,
    input  logic            rst,
    input  logic            in_insert,
    input  logic            in_remove,
    input  logic [BITS-1:0] in_data,
    output logic            out_slow_clk,
    output logic [BITS-1:0] out_data,
    output logic            out_full,
    output logic            out_empty
);
    localparam int unsigned HALF  = FAST_CLK_HZ / (2 * SLOW_CLK_HZ);
    localparam int unsigned CNT_W = (HALF > 1) ? $clog2(HALF) : 1;
    localparam int unsigned DEPTH = 2 ** ADDR_BITS;
    localparam int unsigned PW    = ADDR_BITS + 1;
    // Pointers one lap apart differ in the two top Gray bits only.
    localparam logic [PW-1:0] FULL_MASK = PW'(3) << (ADDR_BITS - 1);

    generate
        if (HALF < 1 || HALF * 2 * SLOW_CLK_HZ != FAST_CLK_HZ) begin : g_bad_ratio
            $error("fast_slow_fifo_bridge: FAST_CLK_HZ/(2*SLOW_CLK_HZ) must be an integer >= 1");
        end
    endgenerate

    function automatic logic [PW-1:0] bin2gray(input logic [PW-1:0] b);
        return b ^ (b >> 1);
    endfunction

    logic [CNT_W-1:0] div_cnt_q, div_cnt_d;
    logic             slow_clk_q, slow_clk_d;
    logic             slow_rise_q, slow_rise_d;
    logic             rst_slow_q, rst_slow_d;

    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    wr_gray_q, wr_gray_d;
    logic [PW-1:0]    rd_gray_s1_q, rd_gray_s1_d;
    logic [PW-1:0]    rd_gray_s2_q, rd_gray_s2_d;
    logic             wr_en;

    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]    rd_gray_q, rd_gray_d;
    logic [PW-1:0]    wr_gray_s1_q, wr_gray_s1_d;
    logic [PW-1:0]    wr_gray_s2_q, wr_gray_s2_d;
    logic             rd_en;

    logic [BITS-1:0]  mem [DEPTH];

    // Divider plus the slow-domain reset, which is held until one slow rising edge
    // has sampled it so every read-side flop sees at least one reset edge.
    always_comb begin
        // NOTE: every always_comb output gets a default first, so no path can infer a latch.
        div_cnt_d   = div_cnt_q + CNT_W'(1);
        slow_clk_d  = slow_clk_q;
        if (div_cnt_q == CNT_W'(HALF - 1)) begin
            div_cnt_d  = '0;
            slow_clk_d = ~slow_clk_q;
        end
        slow_rise_d = slow_clk_d & ~slow_clk_q;
        rst_slow_d  = slow_rise_q ? 1'b0 : rst_slow_q;
        if (rst) begin
            div_cnt_d   = '0;
            slow_clk_d  = CLK_INIT;
            slow_rise_d = 1'b0;
            rst_slow_d  = 1'b1;
        end
    end

    always_comb begin
        wr_en        = in_insert & ~out_full & ~rst;
        wr_ptr_d     = wr_ptr_q + PW'(wr_en);
        wr_gray_d    = bin2gray(wr_ptr_d);
        rd_gray_s1_d = rd_gray_q;
        rd_gray_s2_d = rd_gray_s1_q;
        if (rst) begin
            wr_ptr_d     = '0;
            wr_gray_d    = '0;
            rd_gray_s1_d = '0;
            rd_gray_s2_d = '0;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge fast_clk) begin
        div_cnt_q    <= div_cnt_d;
        slow_clk_q   <= slow_clk_d;
        slow_rise_q  <= slow_rise_d;
        rst_slow_q   <= rst_slow_d;
        wr_ptr_q     <= wr_ptr_d;
        wr_gray_q    <= wr_gray_d;
        rd_gray_s1_q <= rd_gray_s1_d;
        rd_gray_s2_q <= rd_gray_s2_d;
    end

    // NOTE: the storage array has no reset; the pointers alone define which words are valid.
    always_ff @(posedge fast_clk) begin
        if (wr_en) begin
            mem[wr_ptr_q[ADDR_BITS-1:0]] <= in_data;
        end
    end

    always_comb begin
        rd_en        = in_remove & ~out_empty;
        rd_ptr_d     = rd_ptr_q + PW'(rd_en);
        rd_gray_d    = bin2gray(rd_ptr_d);
        wr_gray_s1_d = wr_gray_q;
        wr_gray_s2_d = wr_gray_s1_q;
        if (rst_slow_q) begin
            rd_ptr_d     = '0;
            rd_gray_d    = '0;
            wr_gray_s1_d = '0;
            wr_gray_s2_d = '0;
        end
    end

    always_ff @(posedge slow_clk_q) begin
        rd_ptr_q     <= rd_ptr_d;
        rd_gray_q    <= rd_gray_d;
        wr_gray_s1_q <= wr_gray_s1_d;
        wr_gray_s2_q <= wr_gray_s2_d;
    end

    // Flags compare local pointers against stale synchronised copies, so they clear late.
    assign out_empty    = (rd_gray_q == wr_gray_s2_q);
    assign out_full     = (wr_gray_q == (rd_gray_s2_q ^ FULL_MASK));
    assign out_data     = out_empty ? '0 : mem[rd_ptr_q[ADDR_BITS-1:0]];
    assign out_slow_clk = slow_clk_q;

endmodule

// File: tb/tb_fast_slow_fifo_bridge.sv
// Directed bench for fast_slow_fifo_bridge: scoreboard queue filled on insert,
// drained and compared as the slow domain pops words.
`timescale 1ns/1ps
module tb_fast_slow_fifo_bridge;
    localparam int BITS      = 8;
    localparam int ADDR_BITS = 8;
    localparam int DEPTH     = 2 ** ADDR_BITS;

    logic            fast_clk  = 1'b0;
    logic            rst       = 1'b1;
    logic            in_insert = 1'b0;
    logic            in_remove = 1'b0;
    logic [BITS-1:0] in_data   = '0;
    logic            out_slow_clk;
    logic [BITS-1:0] out_data;
    logic            out_full;
    logic            out_empty;

    int n_checks = 0;
    int n_errors = 0;
    logic [BITS-1:0] exp_q [$];

    fast_slow_fifo_bridge #(
        .FAST_CLK_HZ(40_000_000),
        .SLOW_CLK_HZ(10_000_000),
        .CLK_INIT   (1'b0),
        .BITS       (BITS),
        .ADDR_BITS  (ADDR_BITS)
    ) dut (
        .fast_clk    (fast_clk),
        .rst         (rst),
        .in_insert   (in_insert),
        .in_remove   (in_remove),
        .in_data     (in_data),
        .out_slow_clk(out_slow_clk),
        .out_data    (out_data),
        .out_full    (out_full),
        .out_empty   (out_empty)
    );

    always #5 fast_clk = ~fast_clk;

    initial begin
        #500_000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge fast_clk);
    endtask

    task automatic push_burst(input int n, input int first, input int step);
        for (int i = 0; i < n; i++) begin
            @(negedge fast_clk);
            in_insert = 1'b1;
            in_data   = BITS'(first + i * step);
            exp_q.push_back(in_data);
        end
        @(negedge fast_clk);
        in_insert = 1'b0;
    endtask

    task automatic pop_one(input string tag);
        int              w;
        logic            prev;
        logic            rose;
        logic [BITS-1:0] exp;
        w = 0;
        while (out_empty !== 1'b0 && w < 40) begin
            @(negedge fast_clk);
            w++;
        end
        check({tag, "_ready"}, 32'(out_empty), 32'(0));
        exp = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
        check(tag, 32'(out_data), 32'(exp));
        in_remove = 1'b1;
        prev = out_slow_clk;
        rose = 1'b0;
        w = 0;
        while (!rose && w < 20) begin
            @(negedge fast_clk);
            w++;
            rose = !prev && out_slow_clk;
            prev = out_slow_clk;
        end
        in_remove = 1'b0;
        check({tag, "_rise"}, 32'(rose), 32'(1));
    endtask

    task automatic drain(input int n, input string tag);
        for (int i = 0; i < n; i++) pop_one(tag);
    endtask

    initial begin
        logic [BITS-1:0] cnt;
        logic            prev_slow;
        logic            saw_full;
        int              w;

        // Reset: slow clock parked at CLK_INIT, then toggles every 2 fast cycles.
        for (int i = 0; i < 6; i++) begin
            @(negedge fast_clk);
            check("rst_slow_clk", 32'(out_slow_clk), 32'(0));
        end
        check("rst_full", 32'(out_full), 32'(0));
        rst = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            @(negedge fast_clk);
            check("div_pattern", 32'(out_slow_clk), 32'(((k / 2) % 2) != 0));
        end
        check("idle_empty", 32'(out_empty), 32'(1));
        check("idle_full", 32'(out_full), 32'(0));
        check("idle_data", 32'(out_data), 32'(0));

        // Single word: not visible one fast cycle later, visible within two slow periods.
        @(negedge fast_clk);
        in_insert = 1'b1;
        in_data   = 8'hA5;
        exp_q.push_back(8'hA5);
        @(negedge fast_clk);
        in_insert = 1'b0;
        check("a5_early_empty", 32'(out_empty), 32'(1));
        w = 0;
        while (out_empty !== 1'b0 && w < 10) begin
            @(negedge fast_clk);
            w++;
        end
        check("a5_latency", 32'(out_empty), 32'(0));
        pop_one("a5");
        check("a5_after_empty", 32'(out_empty), 32'(1));
        check("a5_after_data", 32'(out_data), 32'(0));

        // Fill to exactly DEPTH, extra insert dropped, drain in order.
        push_burst(DEPTH - 1, 8'h40, 3);
        check("fill_not_full", 32'(out_full), 32'(0));
        push_burst(1, 8'h40 + (DEPTH - 1) * 3, 3);
        check("fill_full", 32'(out_full), 32'(1));
        @(negedge fast_clk);
        in_insert = 1'b1;
        in_data   = 8'hEE;
        @(negedge fast_clk);
        in_insert = 1'b0;
        check("fill_full_after_drop", 32'(out_full), 32'(1));
        drain(DEPTH, "fill");
        check("fill_drained_empty", 32'(out_empty), 32'(1));
        idle(4);
        check("fill_drained_full", 32'(out_full), 32'(0));

        // Wrap-around: pointers pass the depth boundary twice.
        push_burst(200, 8'h10, 1);
        drain(200, "wrap1");
        push_burst(200, 8'h90, 7);
        drain(200, "wrap2");
        check("wrap_empty", 32'(out_empty), 32'(1));

        // Streaming counter with back-pressure on out_full; slow side pops every cycle.
        cnt       = '0;
        saw_full  = 1'b0;
        in_remove = 1'b1;
        @(negedge fast_clk);
        prev_slow = out_slow_clk;
        for (int cyc = 0; cyc < 6000; cyc++) begin
            @(negedge fast_clk);
            if (prev_slow && !out_slow_clk && !out_empty)
                check("stream", 32'(out_data), 32'((exp_q.size() > 0) ? exp_q.pop_front() : 'x));
            prev_slow = out_slow_clk;
            if (cyc < 1200) begin
                in_insert = 1'b1;
                in_data   = cnt;
                if (!out_full) begin
                    exp_q.push_back(cnt);
                    cnt = cnt + 1'b1;
                end else begin
                    saw_full = 1'b1;
                end
            end else begin
                in_insert = 1'b0;
                if (exp_q.size() == 0) break;
            end
        end
        in_insert = 1'b0;
        idle(12);
        in_remove = 1'b0;
        check("stream_drained", 32'(exp_q.size()), 32'(0));
        check("stream_saw_full", 32'(saw_full), 32'(1));
        check("stream_empty", 32'(out_empty), 32'(1));
        check("stream_not_full", 32'(out_full), 32'(0));

        // Reset with the FIFO half full: contents discarded, new word comes out first.
        push_burst(DEPTH / 2, 8'hC0, 1);
        idle(2);
        rst = 1'b1;
        idle(3);
        exp_q.delete();
        rst = 1'b0;
        idle(10);
        check("midrst_empty", 32'(out_empty), 32'(1));
        check("midrst_full", 32'(out_full), 32'(0));
        check("midrst_data", 32'(out_data), 32'(0));
        push_burst(1, 8'h5A, 0);
        pop_one("midrst_first");
        check("midrst_final_empty", 32'(out_empty), 32'(1));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
